rr_grant_ctrl: RTL and testbench

Client-side companion to the round-robin arbiter. It collects level requests from REQCNT clients, presents a snapshot to the arbiter with a one-cycle valid strobe, and captures the arbiter's returned request number. It then issues a held one-hot grant to that client until the client signals completion or a hold timeout expires. It sits between the clients and the arbiter, one arbitration round at a time.

---
 rtl/rr_grant_ctrl_pkg.sv | 15 +
 rtl/rr_grant_ctrl_if.sv | 30 +++
 rtl/rr_grant_ctrl_hold_timer.sv | 39 +++
 rtl/rr_grant_ctrl.sv | 106 ++++++++++
 tb/tb_rr_grant_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_grant_ctrl_pkg.sv
// Shared types and defaults for the round-robin grant controller.
// The FSM state type is shared so the controller and any observers agree on the encoding.
package rr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        GRANT = 2'd3
    } rr_state_t;

    localparam int REQCNT_DEF   = 5;
    localparam int HOLD_MAX_DEF = 15;

endpackage

// File: rtl/rr_grant_ctrl_if.sv
// Client/arbiter/grant signal bundle for rr_grant_ctrl.
// The master side is the controller; the slave side is the clients plus the arbiter.
interface rr_grant_ctrl_if
    import rr_pkg::*;
#(
    parameter int REQCNT = REQCNT_DEF
);
    localparam int REQWIDTH = $clog2(REQCNT);

    logic [REQCNT-1:0]   cli_req;
    logic [REQCNT-1:0]   cli_done;
    logic [REQCNT-1:0]   arb_req;
    logic                arb_req_val;
    logic [REQWIDTH-1:0] arb_num;
    logic [REQCNT-1:0]   grant;
    logic                grant_val;
    logic [REQWIDTH-1:0] grant_num;
    logic                timeout;

    modport master (
        input  cli_req, cli_done, arb_num,
        output arb_req, arb_req_val, grant, grant_val, grant_num, timeout
    );

    modport slave (
        output cli_req, cli_done, arb_num,
        input  arb_req, arb_req_val, grant, grant_val, grant_num, timeout
    );

endinterface

// File: rtl/rr_grant_ctrl_hold_timer.sv
// Up-counter bounding how long a grant may be held.
// expire_o flags the final permitted GRANT cycle while the timer is enabled.
module rr_hold_timer
    import rr_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CW = $clog2(HOLD_MAX + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Saturate at HOLD_MAX so a stuck enable can never wrap back to a low count.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CW'(HOLD_MAX))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = en_i && (count_q == CW'(HOLD_MAX - 1));

endmodule

// File: rtl/rr_grant_ctrl.sv
// Client-side companion to the round-robin arbiter: snapshot, strobe, capture, held grant.
// One arbitration round at a time; request changes outside IDLE are ignored.
module rr_grant_ctrl
    import rr_pkg::*;
#(
    parameter int REQCNT   = REQCNT_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    rr_grant_ctrl_if.master port_if
);
    localparam int REQWIDTH = $clog2(REQCNT);

    rr_state_t           state_q;
    logic [REQCNT-1:0]   snap_q;
    logic [REQWIDTH-1:0] num_q;
    logic [REQCNT-1:0]   grant_q;
    logic [REQWIDTH-1:0] grant_num_q;
    logic                arb_val_q;
    logic                grant_val_q;

    logic [REQCNT-1:0]   snap_sel;
    logic [REQCNT-1:0]   done_sel;
    logic                num_ok;
    logic                done_hit;
    logic                expire;
    logic                tmr_clr;
    logic                tmr_en;

    // Shifts instead of variable bit-selects keep out-of-range arbiter numbers harmless.
    assign snap_sel = snap_q >> port_if.arb_num;
    assign done_sel = port_if.cli_done >> num_q;
    assign num_ok   = (int'(port_if.arb_num) < REQCNT) && snap_sel[0];
    assign done_hit = done_sel[0];

    assign tmr_clr  = (state_q == WAIT) && num_ok;
    assign tmr_en   = (state_q == GRANT);

    rr_hold_timer #(
        .HOLD_MAX (HOLD_MAX)
    ) u_hold_timer (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expire_o (expire)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            num_q       <= '0;
            grant_q     <= '0;
            grant_num_q <= '0;
            arb_val_q   <= 1'b0;
            grant_val_q <= 1'b0;
        end else begin
            arb_val_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|port_if.cli_req) begin
                        snap_q    <= port_if.cli_req;
                        arb_val_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    num_q <= port_if.arb_num;
                    if (num_ok) begin
                        grant_q     <= REQCNT'(1) << port_if.arb_num;
                        grant_num_q <= port_if.arb_num;
                        grant_val_q <= 1'b1;
                        state_q     <= GRANT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    if (done_hit || expire) begin
                        grant_q     <= '0;
                        grant_num_q <= '0;
                        grant_val_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign port_if.arb_req     = snap_q;
    assign port_if.arb_req_val = arb_val_q;
    assign port_if.grant       = grant_q;
    assign port_if.grant_val   = grant_val_q;
    assign port_if.grant_num   = grant_num_q;
    // A release in the final hold cycle takes precedence, so the pulse is masked by done.
    assign port_if.timeout     = expire && !done_hit;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Self-checking bench for rr_grant_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-offset reference model of a grant round.
module tb_rr_grant_ctrl;
    import rr_pkg::*;

    localparam int N  = 5;
    localparam int HM = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_grant_ctrl_if #(.REQCNT(N)) bus ();

    rr_grant_ctrl #(
        .REQCNT   (N),
        .HOLD_MAX (HM)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .port_if (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: m_pos is the cycle offset within a round
    // (0 idle, 1 strobe, 2 arbiter answer, 3.. grant cycles).
    int          m_pos  = 0;
    logic [N-1:0] m_snap = '0;
    int          m_num  = 0;
    int          rr_last = N - 1;
    int          arb_mode = 0;
    int          arb_fixed = 0;

    int  cyc = 0;
    int  gv_cnt = 0, to_cnt = 0, sv_cnt = 0;
    bit  track = 0;
    bit  prev_gv = 0;
    int  seq_i = 0, last_g = 0;
    int  exp_seq [6] = '{0, 1, 2, 3, 4, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_arb_req"}, bus.arb_req, 0);
        chk({tag, "_arb_val"}, bus.arb_req_val, 0);
        chk({tag, "_grant"}, bus.grant, 0);
        chk({tag, "_grant_val"}, bus.grant_val, 0);
        chk({tag, "_grant_num"}, bus.grant_num, 0);
        chk({tag, "_timeout"}, bus.timeout, 0);
    endtask

    function automatic int pick_rr(input logic [N-1:0] s);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (rr_last + k) % N;
            if (s[c]) return c;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_pos  = 0;
        m_snap = '0;
        m_num  = 0;
    endtask

    task automatic check_outputs(input logic [N-1:0] done_now);
        bit g;
        g = (m_pos >= 3);
        chk("arb_req", bus.arb_req, m_snap);
        chk("arb_req_val", bus.arb_req_val, m_pos == 1);
        chk("grant", bus.grant, g ? (32'd1 << m_num) : 0);
        chk("grant_val", bus.grant_val, g);
        chk("grant_num", bus.grant_num, g ? m_num : 0);
        chk("timeout", bus.timeout, g && (m_pos - 2 == HM) && !done_now[m_num]);
    endtask

    task automatic model_edge(input logic [N-1:0] req, input logic [N-1:0] done, input int arb);
        if (m_pos == 0) begin
            if (req != 0) begin
                m_snap = req;
                m_pos  = 1;
            end
        end else if (m_pos == 1) begin
            m_pos = 2;
        end else if (m_pos == 2) begin
            m_pos = 0;
            if (arb < N) begin
                if (m_snap[arb]) begin
                    m_num = arb;
                    m_pos = 3;
                end
            end
        end else begin
            if (done[m_num] || (m_pos - 2 == HM)) m_pos = 0;
            else m_pos++;
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance model at the rising edge.
    task automatic tick(input logic [N-1:0] req, input logic [N-1:0] done);
        int arb;
        arb = int'($urandom_range(0, 7));
        if (m_pos == 2) begin
            if (arb_mode == 0) arb = arb_fixed;
            else if (arb_mode == 1) begin
                arb = pick_rr(m_snap);
                rr_last = arb;
            end
        end
        bus.cli_req  = req;
        bus.cli_done = done;
        bus.arb_num  = 3'(arb);
        @(negedge clk);
        check_outputs(done);
        if (bus.grant_val === 1'b1) gv_cnt++;
        if (bus.timeout === 1'b1) to_cnt++;
        if (bus.arb_req_val === 1'b1) sv_cnt++;
        if (track && bus.grant_val === 1'b1 && !prev_gv && seq_i < 6) begin
            chk("rr_seq", bus.grant_num, exp_seq[seq_i]);
            if (seq_i > 0) chk("rr_period", cyc - last_g, 4);
            last_g = cyc;
            seq_i++;
        end
        prev_gv = (bus.grant_val === 1'b1);
        @(posedge clk);
        model_edge(req, done, arb);
        cyc++;
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && m_pos != 0; k++) tick('0, '0);
        tick('0, '0);
        if (m_pos != 0) chk("drain_timeout", 1, 0);
    endtask

    task automatic clear_counts();
        gv_cnt = 0;
        to_cnt = 0;
        sv_cnt = 0;
    endtask

    initial begin
        bus.cli_req  = '0;
        bus.cli_done = '0;
        bus.arb_num  = '0;
        model_reset();
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset_hold");
        rst_n = 1'b1;

        // Basic grant: request one cycle, answer 2, done in cycle 5.
        arb_mode = 0; arb_fixed = 2;
        tick(5'b00100, '0);
        for (int k = 1; k < 5; k++) tick('0, '0);
        tick('0, 5'b00100);
        tick('0, '0);
        chk("basic_grant_cycles", gv_cnt, 3);
        drain();

        // Timeout: client 1, no done.
        clear_counts();
        arb_fixed = 1;
        tick(5'b00010, '0);
        for (int k = 0; k < 22; k++) tick('0, '0);
        chk("to_hold_len", gv_cnt, HM);
        chk("to_pulses", to_cnt, 1);
        drain();

        // Done and timeout together; other clients' done bits held high throughout.
        clear_counts();
        tick(5'b00010, '0);
        for (int k = 0; k < 22; k++)
            tick('0, (m_pos - 2 == HM) ? 5'b00010 : 5'b11101);
        chk("dt_hold_len", gv_cnt, HM);
        chk("dt_pulses", to_cnt, 0);
        drain();

        // Invalid arbiter numbers with persistent requests.
        clear_counts();
        arb_fixed = 4;
        for (int k = 0; k < 8; k++) tick(5'b00011, '0);
        arb_fixed = 7;
        for (int k = 0; k < 8; k++) tick(5'b00011, '0);
        chk("inv_no_grant", gv_cnt, 0);
        chk("inv_strobes", sv_cnt, 5);
        drain();

        // Round robin: everyone requests, each releases in its first grant cycle.
        arb_mode = 1; rr_last = N - 1; track = 1; seq_i = 0;
        for (int k = 0; k < 60 && seq_i < 6; k++)
            tick(5'b11111, (m_pos >= 3) ? 5'(32'd1 << m_num) : 5'b00000);
        track = 0;
        chk("rr_rounds", seq_i, 6);
        drain();

        // Asynchronous reset in the middle of a grant to client 3.
        arb_mode = 0; arb_fixed = 3;
        for (int k = 0; k < 10 && m_pos != 4; k++) tick(5'b01000, '0);
        chk("pre_rst_grant", bus.grant, 5'b01000);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        prev_gv = 0;
        @(posedge clk);
        #1;
        chk_zero("rst_held");
        rst_n = 1'b1;
        clear_counts();
        for (int k = 0; k < 6; k++) tick(5'b01000, (m_pos == 4) ? 5'b01000 : 5'b00000);
        chk("post_rst_grants", gv_cnt, 2);
        drain();

        // Randomized traffic across arbiter behaviours.
        for (int k = 0; k < 600; k++) begin
            logic [N-1:0] r, d;
            if ((k % 100) == 0) begin
                arb_mode  = int'($urandom_range(0, 2));
                arb_fixed = int'($urandom_range(0, 7));
            end
            r = ($urandom_range(0, 3) == 0) ? '0 : 5'($urandom);
            d = ($urandom_range(0, 5) == 0) ? 5'($urandom) : '0;
            tick(r, d);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
